ysyx_25060166_lsu: RTL and testbench



---
 rtl/ysyx_25060166_lsu_pkg.sv | 29 ++
 rtl/ysyx_25060166_lsu_align.sv | 81 ++++++++
 rtl/ysyx_25060166_lsu.sv | 151 +++++++++++++++
 tb/tb_ysyx_25060166_lsu.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060166_lsu_pkg.sv
// ============================================================================
// ysyx_25060166_lsu_pkg : widths, funct3 codes and state encoding for the LSU
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_25060166_lsu_pkg;

    localparam int LSU_WIDTH = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_25060166_lsu_align.sv
// ============================================================================
// ysyx_25060166_lsu_align : store lane placement, load extract/extend, fault detect
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_25060166_lsu_align
    import ysyx_25060166_lsu_pkg::*;
#(
    parameter int WIDTH = LSU_WIDTH
) (
    input  logic             we,
    input  logic [2:0]       funct3,
    input  logic [1:0]       addr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] lane_wdata,
    output logic [3:0]       lane_wstrb,
    output logic [WIDTH-1:0] load_data,
    output logic             fault
);

    logic             illegal;
    logic             misaligned;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        if (we) begin
            illegal = (funct3 > F3_SW);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        // funct3[1:0] encodes the access size for every legal code
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
        fault = illegal || misaligned;
    end

    always_comb begin
        lane_wdata = '0;
        lane_wstrb = 4'b0000;
        if (we) begin
            case (funct3)
                F3_SB: begin
                    lane_wdata = {(WIDTH/8){wdata[7:0]}};
                    lane_wstrb = 4'b0001 << addr_lo;
                end
                F3_SH: begin
                    lane_wdata = {(WIDTH/16){wdata[15:0]}};
                    lane_wstrb = 4'b0011 << addr_lo;
                end
                F3_SW: begin
                    lane_wdata = wdata;
                    lane_wstrb = 4'b1111;
                end
                default: begin
                    lane_wdata = '0;
                    lane_wstrb = 4'b0000;
                end
            endcase
        end
    end

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_LB:   load_data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   load_data = rdata;
            F3_LBU:  load_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            F3_LHU:  load_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_25060166_lsu.sv
// ============================================================================
// ysyx_25060166_lsu : single-outstanding load/store unit between EX and WB
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_25060166_lsu
    import ysyx_25060166_lsu_pkg::*;
#(
    parameter int WIDTH = LSU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_err,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);

    lsu_state_e       state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             sel_we;
    logic [2:0]       sel_funct3;
    logic [1:0]       sel_addr_lo;
    logic [WIDTH-1:0] sel_wdata;
    logic [WIDTH-1:0] lane_wdata;
    logic [3:0]       lane_wstrb;
    logic [WIDTH-1:0] load_data;
    logic             fault;
    logic             in_idle;
    logic             in_req;

    assign in_idle = (state_q == ST_IDLE);
    assign in_req  = (state_q == ST_REQ);

    // The single align instance checks the incoming request while idle and
    // works on the captured request for every later state.
    assign sel_we      = in_idle ? req_we          : we_q;
    assign sel_funct3  = in_idle ? req_funct3      : funct3_q;
    assign sel_addr_lo = in_idle ? req_addr[1:0]   : addr_q[1:0];
    assign sel_wdata   = in_idle ? req_wdata       : wdata_q;

    ysyx_25060166_lsu_align #(
        .WIDTH (WIDTH)
    ) u_align (
        .we         (sel_we),
        .funct3     (sel_funct3),
        .addr_lo    (sel_addr_lo),
        .wdata      (sel_wdata),
        .rdata      (mem_rdata),
        .lane_wdata (lane_wdata),
        .lane_wstrb (lane_wstrb),
        .load_data  (load_data),
        .fault      (fault)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = fault;
                    state_d  = fault ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = (we_q || mem_err) ? '0 : load_data;
                    err_d   = mem_err;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = in_idle;
    assign mem_valid  = in_req;
    assign mem_we     = in_req && we_q;
    assign mem_addr   = in_req ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    assign mem_wdata  = in_req ? lane_wdata : '0;
    assign mem_wstrb  = in_req ? lane_wstrb : 4'b0000;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid && err_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25060166_lsu.sv
// ============================================================================
// tb_ysyx_25060166_lsu : directed self-checking bench for the load/store unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_25060166_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid, mem_err;
    logic [31:0] mem_rdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_25060166_lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one request for a single cycle; returns in cycle T+1.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        req_valid  = 1'b0;
    endtask

    // Zero-stall bus: accept now, respond next cycle; returns in cycle T+3.
    task automatic bus(input logic [31:0] rdata, input logic err);
        mem_ready  = 1'b1;
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        mem_err    = err;
        tick();
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        resp_ready = 1'b0;
        tick();
        tick();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // LW, minimum latency
        issue(1'b0, 3'b010, 32'h8000_0004, 32'h0);
        check("lw_mem_valid", {31'd0, mem_valid}, 32'd1);
        check("lw_mem_addr", mem_addr, 32'h8000_0004);
        check("lw_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("lw_mem_we", {31'd0, mem_we}, 32'd0);
        check("lw_req_ready", {31'd0, req_ready}, 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("lw_t2_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("lw_t2_resp_valid", {31'd0, resp_valid}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        check("lw_t3_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("lw_rdata", resp_rdata, 32'hDEAD_BEEF);
        check("lw_err", {31'd0, resp_err}, 32'd0);
        take_resp();
        check("lw_done_req_ready", {31'd0, req_ready}, 32'd1);
        check("lw_done_resp_valid", {31'd0, resp_valid}, 32'd0);

        // Byte/half extraction and extension
        issue(1'b0, 3'b000, 32'h8000_0003, 32'h0);
        check("lb_mem_addr", mem_addr, 32'h8000_0000);
        bus(32'h80FF_0000, 1'b0);
        check("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        take_resp();
        issue(1'b0, 3'b100, 32'h8000_0003, 32'h0);
        bus(32'h80FF_0000, 1'b0);
        check("lbu_rdata", resp_rdata, 32'h0000_0080);
        take_resp();
        issue(1'b0, 3'b001, 32'h8000_0002, 32'h0);
        bus(32'h80FF_0000, 1'b0);
        check("lh_rdata", resp_rdata, 32'hFFFF_80FF);
        take_resp();
        issue(1'b0, 3'b101, 32'h8000_0000, 32'h0);
        bus(32'h1234_8001, 1'b0);
        check("lhu_rdata", resp_rdata, 32'h0000_8001);
        take_resp();

        // Stores
        issue(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD);
        check("sh_mem_we", {31'd0, mem_we}, 32'd1);
        check("sh_mem_wdata", mem_wdata, 32'hABCD_ABCD);
        check("sh_mem_wstrb", {28'd0, mem_wstrb}, 32'hC);
        check("sh_mem_addr", mem_addr, 32'h8000_0000);
        bus(32'hFFFF_FFFF, 1'b0);
        check("sh_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("sh_rdata", resp_rdata, 32'd0);
        check("sh_err", {31'd0, resp_err}, 32'd0);
        take_resp();
        issue(1'b1, 3'b000, 32'h8000_0001, 32'h0000_005A);
        check("sb_mem_wdata", mem_wdata, 32'h5A5A_5A5A);
        check("sb_mem_wstrb", {28'd0, mem_wstrb}, 32'h2);
        bus(32'h0, 1'b0);
        take_resp();

        // Local faults: no bus activity, response at T+1
        issue(1'b0, 3'b010, 32'h8000_0002, 32'h0);
        check("mis_lw_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("mis_lw_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("mis_lw_err", {31'd0, resp_err}, 32'd1);
        check("mis_lw_rdata", resp_rdata, 32'd0);
        take_resp();
        issue(1'b0, 3'b011, 32'h8000_0000, 32'h0);
        check("ill_ld_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("ill_ld_err", {31'd0, resp_err}, 32'd1);
        take_resp();
        issue(1'b1, 3'b011, 32'h8000_0000, 32'h0);
        check("ill_st_err", {31'd0, resp_err}, 32'd1);
        take_resp();
        issue(1'b0, 3'b001, 32'h8000_0001, 32'h0);
        check("mis_lh_err", {31'd0, resp_err}, 32'd1);
        take_resp();

        // resp_ready while idle has no effect
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("idle_rr_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("idle_rr_req_ready", {31'd0, req_ready}, 32'd1);

        // Bus stall, stray rvalid in REQ, bus error, WB backpressure
        issue(1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D);
        mem_rvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("stall_mem_valid", {31'd0, mem_valid}, 32'd1);
            check("stall_mem_addr", mem_addr, 32'h8000_0008);
            check("stall_mem_wdata", mem_wdata, 32'hCAFE_F00D);
            check("stall_mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            mem_ready = (i == 5);
            tick();
            mem_rvalid = 1'b0;
        end
        mem_ready = 1'b0;
        check("stall_wait_mem_valid", {31'd0, mem_valid}, 32'd0);
        mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_rvalid = 1'b0; mem_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_resp_err", {31'd0, resp_err}, 32'd1);
            check("hold_resp_rdata", resp_rdata, 32'd0);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        take_resp();
        check("hold_done_req_ready", {31'd0, req_ready}, 32'd1);

        // Asynchronous reset while waiting for the bus response
        issue(1'b0, 3'b010, 32'h8000_0010, 32'h0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("pre_rst_req_ready", {31'd0, req_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req_ready", {31'd0, req_ready}, 32'd1);
        check("arst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_rvalid = 1'b0;
        check("stray_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("stray_req_ready", {31'd0, req_ready}, 32'd1);

        // Unit still operates normally after reset
        issue(1'b0, 3'b010, 32'h8000_0020, 32'h0);
        bus(32'h0BAD_F00D, 1'b0);
        check("post_rst_rdata", resp_rdata, 32'h0BAD_F00D);
        take_resp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
